activation_writer_bram: RTL and testbench
=========================================

// Module: activation_writer_bram
// PURPOSE
//  Writes a flat bus of NUM_ELEMS W-bit layer results into the shared 8-bit BRAM at consecutive
//  addresses from BASE_ADDR. One element is written per cycle. It is the store-side counterpart of the
//  layer weight loaders: an FC layer's packed output is sent back to BRAM for the next layer to fetch.
//  Drives an external BRAM port (en/ren/wen/addr/din/dout, 2-cycle read latency).
// PARAMETERS
//  NUM_ELEMS   8    number of elements in data_in
//  W           8    element width; must equal BRAM data width (8)
//  ADDR_WIDTH  18   BRAM address width
//  BASE_ADDR   0    first BRAM address written; BASE_ADDR+NUM_ELEMS-1 < 2**ADDR_WIDTH (elaboration error otherwise)
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  rst        in   1              synchronous, active-high reset
//  start      in   1              begin a store; sampled only in IDLE or DONE
//  data_in    in   NUM_ELEMS*W    packed elements, element i = data_in[i*W +: W]
//  bram_en    out  1              BRAM enable
//  bram_ren   out  1              BRAM read enable (readback only)
//  bram_wen   out  1              BRAM write enable
//  bram_addr  out  ADDR_WIDTH     BRAM address
//  bram_din   out  W              BRAM write data
//  bram_dout  in   W              BRAM read data, valid 2 cycles after ren/addr are sampled
//  done       out  1              store complete; held high until next accepted start or rst
//  verify_err out  1              sticky readback mismatch (always 0 when feature compiled out)
// BEHAVIOUR
//  - Reset: state=IDLE; bram_en/ren/wen=0, bram_addr=BASE_ADDR, bram_din=0, done=0, verify_err=0, counters=0.
//  - All outputs registered. FSM: IDLE -> WRITE -> [VERIFY -> DRAIN] -> DONE. A start seen in DONE -> WRITE.
//  - Accept (edge k, start=1 in IDLE/DONE): snapshot data_in into internal reg; done<=0, verify_err<=0;
//    en=1, wen=1, addr=BASE_ADDR, din=elem0. Later data_in changes do not affect this store.
//  - WRITE: each edge advances idx: addr=BASE_ADDR+idx, din=elem[idx]. BRAM captures elem i at edge k+1+i.
//  - At edge k+NUM_ELEMS, after the last element has been captured: en=0, wen=0, addr=BASE_ADDR.
//    Without feature: state=DONE, done=1, so done is high NUM_ELEMS cycles after the start edge.
//  - start while in WRITE/VERIFY/DRAIN: ignored. No queueing.
//  - rst at any cycle overrides all activity and returns to reset values. The partial store is abandoned.
//  - NUM_ELEMS=1: a single write cycle, then DONE. idx counter width = $clog2(NUM_ELEMS+1).
//  - Address never wraps. The parameter check guarantees the range fits.
// CONFIGURATION
//  Macro ACT_WRITER_READBACK_EN:
//   defined: after WRITE, VERIFY issues en=1, ren=1 reads at BASE_ADDR..BASE_ADDR+NUM_ELEMS-1, one per cycle.
//     A compare pipeline delayed by 2 cycles checks bram_dout against the snapshot. Any mismatch sets verify_err
//     (sticky until next accept/rst). DRAIN holds ren=0 for the 2 trailing compares. DONE/done=1 follows at
//     edge k+2*NUM_ELEMS+2.
//   undefined: no VERIFY/DRAIN states. bram_ren tied 0, bram_dout ignored, verify_err tied 0.
// STRUCTURE
//  - Shared package layer_mem_pkg: BRAM_DW=8, BRAM_RD_LAT=2, BRAM_ADDR_WIDTH=18, per-layer base-address
//    constants, FSM state enum (IDLE/WRITE/VERIFY/DRAIN/DONE).
//  - One sub-module under the macro: bram_readback_checker. It holds the 2-stage expected-data/valid delay line,
//    the compare and the sticky flag.
// TESTING  (behavioural BRAM model, 2-cycle read latency; NUM_ELEMS=4, W=8, BASE_ADDR=16)
//  1. data_in=32'hDDCCBBAA, start pulse -> mem[16..19]=AA,BB,CC,DD; wen high exactly 4 cycles;
//     done=1 at 4 cycles after the start edge (10 with macro).
//  2. Change data_in to 32'h0 one cycle after start -> memory still holds AA,BB,CC,DD.
//  3. start pulsed again at write 2 -> ignored; exactly 4 writes. A start in DONE with 32'h44332211
//     -> done drops, mem[16..19]=11,22,33,44.
//  4. rst asserted during write 2 -> next edge en=wen=0, done=0, addr=16; mem[18..19] unchanged.
//  5. (macro) model corrupts mem[18] to 8'hFF after write -> verify_err=1 at done. A clean rerun -> verify_err=0.
//  6. NUM_ELEMS=1, BASE_ADDR=2**18-1, data 8'h5A -> single write to the top address, done after 1 cycle.

Source files
------------

// File: rtl/layer_mem_pkg.sv
// Shared BRAM geometry, per-layer base addresses and the store FSM state type.
package layer_mem_pkg;
  localparam int BRAM_DW         = 8;
  localparam int BRAM_RD_LAT     = 2;
  localparam int BRAM_ADDR_WIDTH = 18;

  localparam logic [BRAM_ADDR_WIDTH-1:0] L1_WEIGHT_BASE = 18'h00000;
  localparam logic [BRAM_ADDR_WIDTH-1:0] L1_ACT_BASE    = 18'h10000;
  localparam logic [BRAM_ADDR_WIDTH-1:0] L2_WEIGHT_BASE = 18'h20000;
  localparam logic [BRAM_ADDR_WIDTH-1:0] L2_ACT_BASE    = 18'h30000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_DRAIN,
    ST_DONE
  } wr_state_t;
endpackage

// File: rtl/bram_readback_checker.sv
// Delays expected data/valid by the BRAM read latency and compares against read data.
// The mismatch flag is sticky until i_clr or i_rst.
module bram_readback_checker
  import layer_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_rd_vld,
  input  logic [W-1:0] i_exp_dat,
  input  logic [W-1:0] i_bram_dout,
  output logic         o_err
);
  logic         r_vld0, r_vld1;
  logic [W-1:0] r_exp0, r_exp1;
  logic         r_err;

  // Stage 0 aligns with the BRAM sampling the read; stage 1 lines up with dout.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      r_exp0 <= '0;
      r_exp1 <= '0;
      r_err  <= 1'b0;
    end else begin
      r_vld0 <= i_rd_vld;
      r_exp0 <= i_exp_dat;
      r_vld1 <= r_vld0;
      r_exp1 <= r_exp0;
      if (r_vld1 && (i_bram_dout != r_exp1)) r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
endmodule

// File: rtl/activation_writer_bram.sv
// Stores NUM_ELEMS packed W-bit results into BRAM from BASE_ADDR, one per cycle.
// Optional readback verify with ACT_WRITER_READBACK_EN.
module activation_writer_bram
  import layer_mem_pkg::*;
#(
  parameter int NUM_ELEMS  = 8,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NUM_ELEMS*W-1:0] i_data_in,
  output logic                  o_bram_en,
  output logic                  o_bram_ren,
  output logic                  o_bram_wen,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [W-1:0]          o_bram_din,
  input  logic [W-1:0]          i_bram_dout,
  output logic                  o_done,
  output logic                  o_verify_err
);
  localparam int IDX_W = $clog2(NUM_ELEMS + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_ELEMS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);

  if (W != BRAM_DW) begin : g_bad_width
    $error("activation_writer_bram: W must equal the BRAM data width");
  end
  if (NUM_ELEMS < 1 ||
      (longint'(BASE_ADDR) + longint'(NUM_ELEMS) - 1) >= (longint'(1) << ADDR_WIDTH)) begin : g_bad_range
    $error("activation_writer_bram: address range does not fit ADDR_WIDTH");
  end

  function automatic logic [W-1:0] elem_at(input logic [NUM_ELEMS*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  wr_state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt, w_nidx;
  logic [NUM_ELEMS*W-1:0] r_snap;
  logic                  r_en, r_ren, r_wen, r_done;
  logic                  w_en, w_ren, w_wen, w_done;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr, w_next_addr;
  logic [W-1:0]          r_din, w_din;
  logic                  w_accept;

  assign w_accept    = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_nidx      = r_idx + IDX_W'(1);
  assign w_next_addr = BASE_A + ADDR_WIDTH'(w_nidx);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_snap  <= '0;
      r_en    <= 1'b0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= BASE_A;
      r_din   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_en    <= w_en;
      r_ren   <= w_ren;
      r_wen   <= w_wen;
      r_addr  <= w_addr;
      r_din   <= w_din;
      r_done  <= w_done;
      if (w_accept) r_snap <= i_data_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_en        = 1'b0;
    w_ren       = 1'b0;
    w_wen       = 1'b0;
    w_addr      = BASE_A;
    w_din       = r_din;
    w_done      = r_done;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = ST_WRITE;
          w_idx_nxt   = '0;
          w_en        = 1'b1;
          w_wen       = 1'b1;
          w_din       = i_data_in[W-1:0];
          w_done      = 1'b0;
        end
      end
      ST_WRITE: begin
        if (r_idx == LAST_IDX) begin
          w_idx_nxt = '0;
`ifdef ACT_WRITER_READBACK_EN
          w_state_nxt = ST_VERIFY;
          w_en        = 1'b1;
          w_ren       = 1'b1;
`else
          w_state_nxt = ST_DONE;
          w_done      = 1'b1;
`endif
        end else begin
          w_idx_nxt = w_nidx;
          w_en      = 1'b1;
          w_wen     = 1'b1;
          w_addr    = w_next_addr;
          w_din     = elem_at(r_snap, int'(w_nidx));
        end
      end
`ifdef ACT_WRITER_READBACK_EN
      ST_VERIFY: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DRAIN;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = w_nidx;
          w_en      = 1'b1;
          w_ren     = 1'b1;
          w_addr    = w_next_addr;
        end
      end
      // r_idx counts the trailing compare cycles still in the read pipeline.
      ST_DRAIN: begin
        if (r_idx == IDX_W'(1)) begin
          w_state_nxt = ST_DONE;
          w_idx_nxt   = '0;
          w_done      = 1'b1;
        end else begin
          w_idx_nxt = w_nidx;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef ACT_WRITER_READBACK_EN
  logic w_verify_err;

  bram_readback_checker #(.W(W)) u_checker (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_accept),
    .i_rd_vld    (r_ren),
    .i_exp_dat   (elem_at(r_snap, int'(r_idx))),
    .i_bram_dout (i_bram_dout),
    .o_err       (w_verify_err)
  );
  assign o_verify_err = w_verify_err;
`else
  logic w_unused_dout;
  assign w_unused_dout = ^i_bram_dout;
  assign o_verify_err  = 1'b0;
`endif

  assign o_bram_en   = r_en;
  assign o_bram_ren  = r_ren;
  assign o_bram_wen  = r_wen;
  assign o_bram_addr = r_addr;
  assign o_bram_din  = r_din;
  assign o_done      = r_done;
endmodule

// File: tb/tb_activation_writer_bram.sv
// Bench for activation_writer_bram: behavioural 2-cycle BRAM models, random stores vs. a byte-level reference.
module tb_activation_writer_bram;
  localparam int N    = 4;
  localparam int BASE = 16;
  localparam int AW   = 18;
`ifdef ACT_WRITER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int LAT_A = RB ? 2*N + 2 : N;
  localparam int LAT_B = RB ? 4 : 1;
  localparam logic [AW-1:0] TOP = 18'h3FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start_a, start_b;
  logic [N*8-1:0] data_a;
  logic [7:0]    data_b;
  logic          en_a, ren_a, wen_a, done_a, verr_a;
  logic [AW-1:0] addr_a;
  logic [7:0]    din_a, dout_a;
  logic          en_b, ren_b, wen_b, done_b, verr_b;
  logic [AW-1:0] addr_b;
  logic [7:0]    din_b, dout_b;

  activation_writer_bram #(.NUM_ELEMS(N), .W(8), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_data_in(data_a),
    .o_bram_en(en_a), .o_bram_ren(ren_a), .o_bram_wen(wen_a), .o_bram_addr(addr_a),
    .o_bram_din(din_a), .i_bram_dout(dout_a), .o_done(done_a), .o_verify_err(verr_a));

  activation_writer_bram #(.NUM_ELEMS(1), .W(8), .ADDR_WIDTH(AW), .BASE_ADDR(262143)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_data_in(data_b),
    .o_bram_en(en_b), .o_bram_ren(ren_b), .o_bram_wen(wen_b), .o_bram_addr(addr_b),
    .o_bram_din(din_b), .i_bram_dout(dout_b), .o_done(done_b), .o_verify_err(verr_b));

  // BRAM model A: 64-byte window, optional corruption of one address on write.
  logic [7:0] mem_a [0:63] = '{default: 8'h00};
  logic [7:0] rd1_a = 8'h00;
  int wr_cnt_a = 0, wen_cnt_a = 0, ren_cnt_a = 0, stray_a = 0;
  int corrupt_addr = -1;
  always @(posedge clk) begin
    if (wen_a) wen_cnt_a++;
    if (en_a && wen_a) begin
      wr_cnt_a++;
      if (int'(addr_a) < BASE || int'(addr_a) >= BASE + N) stray_a++;
      mem_a[addr_a[5:0]] <= (int'(addr_a) == corrupt_addr) ? 8'hFF : din_a;
    end
    if (en_a && ren_a) ren_cnt_a++;
    rd1_a  <= (en_a && ren_a) ? mem_a[addr_a[5:0]] : 8'h00;
    dout_a <= rd1_a;
  end

  // BRAM model B: only the top address exists.
  logic [7:0]    mem_b = 8'h00, rd1_b = 8'h00;
  logic [AW-1:0] last_addr_b = '0;
  int wr_cnt_b = 0;
  always @(posedge clk) begin
    if (en_b && wen_b) begin
      wr_cnt_b++;
      last_addr_b <= addr_b;
      mem_b       <= din_b;
    end
    rd1_b  <= (en_b && ren_b && addr_b == TOP) ? mem_b : 8'h00;
    dout_b <= rd1_b;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one store on DUT A from posedge+1, returns at posedge+1 of the done cycle.
  task automatic run_store(input logic [31:0] d, input bit scramble, input logic [31:0] newd,
                           input bit spurious, input string tag);
    int w0, e0, r0, lat;
    logic [7:0] exp_b;
    bit exp_err;
    w0 = wr_cnt_a; e0 = wen_cnt_a; r0 = ren_cnt_a; lat = 0;
    data_a = d; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check({tag, "_done_clr"}, done_a, 0);
    if (scramble) data_a = newd;
    for (int c = 1; c <= 60; c++) begin
      if (spurious && c == 2) start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      if (done_a) begin lat = c; break; end
    end
    check({tag, "_latency"}, lat, LAT_A);
    check({tag, "_writes"}, wr_cnt_a - w0, N);
    check({tag, "_wen_cycles"}, wen_cnt_a - e0, N);
    check({tag, "_reads"}, ren_cnt_a - r0, RB ? N : 0);
    check({tag, "_idle_bus"}, {en_a, wen_a, ren_a}, 3'b000);
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_b = d[i*8 +: 8];
      if (BASE + i == corrupt_addr) begin
        if (RB && exp_b != 8'hFF) exp_err = 1'b1;
        exp_b = 8'hFF;
      end
      check($sformatf("%s_mem%0d", tag, BASE + i), mem_a[BASE + i], exp_b);
    end
    check({tag, "_verify_err"}, verr_a, exp_err);
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", en_a, 0);
    check("rst_ren", ren_a, 0);
    check("rst_wen", wen_a, 0);
    check("rst_addr", addr_a, BASE);
    check("rst_din", din_a, 0);
    check("rst_done", done_a, 0);
    check("rst_verr", verr_a, 0);
    check("rst_addr_b", addr_b, TOP);
    rst = 1'b0;
    @(posedge clk); #1;

    run_store(32'hDDCCBBAA, 1'b0, 32'h0, 1'b0, "t1");
    run_store(32'hDDCCBBAA ^ 32'h01010101, 1'b0, 32'h0, 1'b0, "t2pre");
    run_store(32'hDDCCBBAA, 1'b1, 32'h0, 1'b0, "t2");
    run_store(32'h55667788, 1'b0, 32'h0, 1'b1, "t3a");
    repeat (2) @(posedge clk);
    #1;
    check("t3_done_held", done_a, 1);
    run_store(32'h44332211, 1'b0, 32'h0, 1'b0, "t3b");

    // Reset lands on the edge that would present element 2.
    data_a = 32'hA1B2C3D4; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t4_en", en_a, 0);
    check("t4_wen", wen_a, 0);
    check("t4_done", done_a, 0);
    check("t4_addr", addr_a, BASE);
    repeat (4) @(posedge clk);
    #1;
    check("t4_mem16", mem_a[16], 8'hD4);
    check("t4_mem17", mem_a[17], 8'hC3);
    check("t4_mem18", mem_a[18], 8'h33);
    check("t4_mem19", mem_a[19], 8'h44);
    check("t4_stay_idle", done_a, 0);

    corrupt_addr = 18;
    run_store(32'h87654321, 1'b0, 32'h0, 1'b0, "t5bad");
    corrupt_addr = -1;
    run_store(32'h87654321, 1'b0, 32'h0, 1'b0, "t5clean");

    for (int it = 0; it < 8; it++) begin
      d = $urandom;
      run_store(d, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", it));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    check("stray_writes", stray_a, 0);

    data_b = 8'h5A; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    data_b = 8'h00;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done_b) begin lat = c; break; end
    end
    check("t6_latency", lat, LAT_B);
    check("t6_writes", wr_cnt_b, 1);
    check("t6_addr", last_addr_b, TOP);
    check("t6_data", mem_b, 8'h5A);
    check("t6_verr", verr_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
